// File: rtl/fa_checker.sv
// fa_checker: receiving-end response checker for the 1-bit full adder.
// Accepts (a, b, cin, sum, cout) beats over valid/ready and recomputes the
// expected result. Over one run of VEC_COUNT beats it accumulates vector,
// error and coverage statistics, then holds a registered pass/fail verdict.
// Optional feature macro: FA_CHECK_COV_EN. When it is defined, the block
// tracks combination coverage and requires full coverage for pass. When it
// is undefined, cov is tied to zero and pass depends on errors only.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start; beats not accepted
// ST_RUN   | accepting beats until VEC_COUNT have been taken
// ST_DONE  | verdict valid, statistics frozen; start begins a new run

module fa_checker #(
   parameter int VEC_COUNT = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a,
   input  logic             b,
   input  logic             cin,
   input  logic             sum,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             mismatch,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [7:0]       cov
);

   // The run length is tracked by its own down-counter, so a run may be
   // longer than vec_cnt can represent and vec_cnt simply wraps.
   localparam int REM_W = (VEC_COUNT < 2) ? 1 : $clog2(VEC_COUNT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
   logic               mismatch_q, mismatch_d;
   logic               pass_q, pass_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   // Goes high one edge after reset release. Until then, start is ignored,
   // so a start that coincides with reset deassertion cannot launch a run.
   logic               start_ok_q, start_ok_d;

   logic               accept;
   logic               sum_e;
   logic               cout_e;
   logic               beat_bad;
   logic               cov_full;

`ifdef FA_CHECK_COV_EN
   logic [7:0]         cov_q, cov_d;
`endif

   // Expected adder response and acceptance of the current beat.
   always_comb begin
      accept   = in_valid && busy_q;
      sum_e    = a ^ b ^ cin;
      cout_e   = (a & b) | (cin & (a ^ b));
      beat_bad = accept && ({sum, cout} != {sum_e, cout_e});
   end

   // Next-state and statistics update.
   always_comb begin
      state_d         = state_q;
      rem_d           = rem_q;
      vec_cnt_d       = vec_cnt_q;
      err_cnt_d       = err_cnt_q;
      first_err_idx_d = first_err_idx_q;
      pass_d          = pass_q;
      mismatch_d      = 1'b0;
      start_ok_d      = 1'b1;
      cov_full        = 1'b1;
`ifdef FA_CHECK_COV_EN
      cov_d           = cov_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start && start_ok_q) begin
               state_d         = ST_RUN;
               rem_d           = REM_W'(VEC_COUNT);
               vec_cnt_d       = '0;
               err_cnt_d       = '0;
               first_err_idx_d = '1;
               pass_d          = 1'b0;
`ifdef FA_CHECK_COV_EN
               cov_d           = '0;
`endif
            end
         end
         ST_RUN: begin
            if (accept) begin
               vec_cnt_d = vec_cnt_q + CNT_W'(1);
               rem_d     = rem_q - REM_W'(1);
`ifdef FA_CHECK_COV_EN
               cov_d[{a, b, cin}] = 1'b1;
`endif
               if (beat_bad) begin
                  mismatch_d = 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  end
                  if (first_err_idx_q == '1) begin
                     first_err_idx_d = vec_cnt_q;
                  end
               end
               if (rem_q == REM_W'(1)) begin
                  state_d = ST_DONE;
`ifdef FA_CHECK_COV_EN
                  cov_full = (cov_d == 8'hFF);
`endif
                  pass_d = (err_cnt_d == '0) && cov_full;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State and statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         rem_q           <= '0;
         vec_cnt_q       <= '0;
         err_cnt_q       <= '0;
         first_err_idx_q <= '1;
         mismatch_q      <= 1'b0;
         pass_q          <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         start_ok_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         vec_cnt_q       <= vec_cnt_d;
         err_cnt_q       <= err_cnt_d;
         first_err_idx_q <= first_err_idx_d;
         mismatch_q      <= mismatch_d;
         pass_q          <= pass_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         start_ok_q      <= start_ok_d;
      end
   end

`ifdef FA_CHECK_COV_EN
   // Combination coverage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cov_q <= '0;
      end else begin
         cov_q <= cov_d;
      end
   end

   assign cov = cov_q;
`else
   assign cov = 8'h00;
`endif

   assign in_ready      = busy_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign mismatch      = mismatch_q;
   assign vec_cnt       = vec_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_fa_checker.sv
// Directed bench for fa_checker: one instance with the default run length
// and one with a 300-beat run for counter wrap and saturation.
// Expected values are hand-derived; expectations that depend on
// FA_CHECK_COV_EN follow that macro.

module tb_fa_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       start2;
   logic       in_valid;
   logic       a, b, cin, sum, cout;

   logic       in_ready, busy, done, pass, mismatch;
   logic [7:0] vec_cnt, err_cnt, first_err_idx, cov;

   logic       in_ready2, busy2, done2, pass2, mismatch2;
   logic [7:0] vec_cnt2, err_cnt2, first_err_idx2, cov2;

   int         total;
   int         bad;

   // Full-adder truth table, indexed by {a,b,cin}.
   logic [7:0] sum_tab;
   logic [7:0] cout_tab;

   logic       cov_en;
   logic [7:0] cov_full_exp;
   logic [7:0] cov_zero_exp;
   logic       pass_single_exp;

   fa_checker #(.VEC_COUNT(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
      .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
      .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .cov(cov)
   );

   fa_checker #(.VEC_COUNT(300), .CNT_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid),
      .in_ready(in_ready2), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
      .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
      .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .first_err_idx(first_err_idx2),
      .cov(cov2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat; flip_sum corrupts the reported sum. Samples after the edge.
   task automatic beat(input logic [2:0] combo, input logic flip_sum);
      {a, b, cin} = combo;
      sum         = sum_tab[combo] ^ flip_sum;
      cout        = cout_tab[combo];
      in_valid    = 1'b1;
      tick();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_mismatch"}, mismatch, 0);
      check({tag, "_vec_cnt"}, vec_cnt, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
      check({tag, "_first_err"}, first_err_idx, 8'hFF);
      check({tag, "_cov"}, cov, 0);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      sum_tab  = 8'h96;
      cout_tab = 8'hE8;
`ifdef FA_CHECK_COV_EN
      cov_en = 1'b1;
`else
      cov_en = 1'b0;
`endif
      cov_full_exp    = cov_en ? 8'hFF : 8'h00;
      cov_zero_exp    = cov_en ? 8'h01 : 8'h00;
      pass_single_exp = ~cov_en;

      rst_n    = 1'b0;
      start    = 1'b0;
      start2   = 1'b0;
      in_valid = 1'b0;
      {a, b, cin, sum, cout} = 5'b0;

      // Reset values.
      tick();
      tick();
      check_reset_values("rst");
      rst_n = 1'b1;
      tick();

      // Run 1: all eight combinations, correct responses.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("r1_busy", busy, 1);
      check("r1_in_ready", in_ready, 1);
      check("r1_vec0", vec_cnt, 0);
      for (int i = 0; i < 8; i++) begin
         beat(3'(i), 1'b0);
         check("r1_vec", vec_cnt, i + 1);
         check("r1_mismatch", mismatch, 0);
         if (i < 7) check("r1_not_done", done, 0);
      end
      in_valid = 1'b0;
      check("r1_done", done, 1);
      check("r1_busy_low", busy, 0);
      check("r1_ready_low", in_ready, 0);
      check("r1_err", err_cnt, 0);
      check("r1_cov", cov, cov_full_exp);
      check("r1_pass", pass, 1);
      check("r1_first_err", first_err_idx, 8'hFF);

      // Run 2: beat with index 3 (a=0,b=1,cin=1) reports sum=1.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("r2_busy", busy, 1);
      check("r2_vec_clr", vec_cnt, 0);
      for (int i = 0; i < 8; i++) begin
         beat(3'(i), i == 3);
         if (i == 3) begin
            check("r2_mismatch_pulse", mismatch, 1);
            check("r2_err_at3", err_cnt, 1);
            check("r2_first_err_at3", first_err_idx, 3);
         end else begin
            check("r2_mismatch_quiet", mismatch, 0);
         end
      end
      in_valid = 1'b0;
      check("r2_done", done, 1);
      check("r2_err", err_cnt, 1);
      check("r2_first_err", first_err_idx, 3);
      check("r2_pass", pass, 0);
      check("r2_vec", vec_cnt, 8);

      // DONE: a wrong beat is not accepted and changes nothing.
      beat(3'd5, 1'b1);
      beat(3'd6, 1'b1);
      in_valid = 1'b0;
      check("dn_vec", vec_cnt, 8);
      check("dn_err", err_cnt, 1);
      check("dn_first_err", first_err_idx, 3);
      check("dn_mismatch", mismatch, 0);
      check("dn_done", done, 1);
      check("dn_pass", pass, 0);

      // Run 3 from DONE: all beats are {0,0,0}; checks the coverage rule.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("r3_busy", busy, 1);
      check("r3_done_low", done, 0);
      check("r3_vec_clr", vec_cnt, 0);
      check("r3_err_clr", err_cnt, 0);
      check("r3_first_clr", first_err_idx, 8'hFF);
      check("r3_cov_clr", cov, 0);
      for (int i = 0; i < 8; i++) beat(3'd0, 1'b0);
      in_valid = 1'b0;
      check("r3_done", done, 1);
      check("r3_err", err_cnt, 0);
      check("r3_cov", cov, cov_zero_exp);
      check("r3_pass", pass, pass_single_exp);

      // Run 4: reset asserted after 4 beats.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) beat(3'(i), 1'b1);
      check("r4_err_before_rst", err_cnt, 4);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("r4rst");
      in_valid = 1'b0;
      tick();
      // Release reset with start already high: the first edge ignores start.
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      check("r4_start_ignored_busy", busy, 0);
      check("r4_start_ignored_done", done, 0);
      tick();
      start = 1'b0;
      check("r4_busy", busy, 1);
      for (int i = 7; i >= 0; i--) beat(3'(i), 1'b0);
      in_valid = 1'b0;
      check("r4_done", done, 1);
      check("r4_vec", vec_cnt, 8);
      check("r4_err", err_cnt, 0);
      check("r4_pass", pass, 1);

      // Long run: 300 wrong beats on the second instance.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("l_busy", busy2, 1);
      for (int i = 0; i < 300; i++) begin
         beat(3'(i % 8), 1'b1);
         if (i == 0) check("l_first_err_0", first_err_idx2, 0);
         if (i == 254) check("l_err_255", err_cnt2, 255);
         if (i == 298) begin
            check("l_not_done_299", done2, 0);
            check("l_ready_299", in_ready2, 1);
         end
      end
      in_valid = 1'b0;
      check("l_done", done2, 1);
      check("l_busy_low", busy2, 0);
      check("l_ready_low", in_ready2, 0);
      check("l_err_sat", err_cnt2, 255);
      check("l_first_err", first_err_idx2, 0);
      check("l_vec_wrap", vec_cnt2, 44);
      check("l_mismatch_last", mismatch2, 1);
      check("l_pass", pass2, 0);
      check("l_cov", cov2, cov_full_exp);
      tick();
      check("l_mismatch_clear", mismatch2, 0);
      check("l_dut1_untouched", vec_cnt, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
